multi_frame_uart_receiver: RTL

//  Oversampled UART receiver. Assembles FRAMES consecutive serial frames into one

---
 rtl/multi_frame_uart_receiver.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/multi_frame_uart_receiver.sv
// ============================================================================
// Module  : multi_frame_uart_receiver
// Brief   : Oversampled UART receiver that packs FRAMES serial frames into one
//           parallel word behind a single-entry valid/ready holding register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_frame_uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int FRAMES     = 2,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int TIMEOUT    = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          serial_in,
    output logic [FRAMES*DATA_BITS-1:0]   word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          timeout,
    output logic                          busy
);

    localparam int WORD_W = FRAMES * DATA_BITS;
    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 3);
    localparam int FRM_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int GAP_W  = $clog2(TIMEOUT * OVERSAMPLE + 1);

    localparam logic [CNT_W-1:0] MID_CNT    = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(FRAMES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(TIMEOUT * OVERSAMPLE - 1);
    localparam logic             PAR_ODD    = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5,
        S_BREAK  = 3'd6
    } state_t;

    state_t               state;
    logic                 sync_1;
    logic                 line;
    logic                 line_prev;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [FRM_W-1:0]     frame_idx;
    logic [GAP_W-1:0]     gap_cnt;
    logic [DATA_BITS-1:0] frame_data;
    logic [WORD_W-1:0]    shift_reg;
    logic                 par_bad;
    logic                 fall;
    logic [WORD_W-1:0]    assembled;

    assign fall = line_prev & ~line;
    // Earlier frames move up one slot so the first frame ends in the MS slot.
    assign assembled = (shift_reg << DATA_BITS) | WORD_W'(frame_data);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            sync_1     <= 1'b1;
            line       <= 1'b1;
            line_prev  <= 1'b1;
            cnt        <= '0;
            bit_cnt    <= '0;
            frame_idx  <= '0;
            gap_cnt    <= '0;
            frame_data <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sync_1     <= serial_in;
            line       <= sync_1;
            line_prev  <= line;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;

            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end

                S_START: begin
                    if (cnt == MID_CNT) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                        if (line) begin
                            state     <= S_IDLE;
                            frame_idx <= '0;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt        <= '0;
                        frame_data <= {line, frame_data[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt     <= '0;
                        par_bad <= line ^ (^frame_data) ^ PAR_ODD;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (!line) begin
                            frame_err <= 1'b1;
                            frame_idx <= '0;
                            state     <= S_BREAK;
                        end else if (bit_cnt != STOP_LAST) begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
                            frame_idx  <= '0;
                            state      <= S_IDLE;
                        end else if (frame_idx != FRAME_LAST) begin
                            shift_reg <= assembled;
                            frame_idx <= frame_idx + FRM_W'(1);
                            gap_cnt   <= '0;
                            state     <= S_GAP;
                        end else begin
                            frame_idx <= '0;
                            state     <= S_IDLE;
                            if (!word_valid || word_ready) begin
                                word_out   <= assembled;
                                word_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_GAP: begin
                    if (fall) begin
                        state <= S_START;
                        cnt   <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        timeout   <= 1'b1;
                        frame_idx <= '0;
                        state     <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                S_BREAK: begin
                    // Any low sample restarts the full high bit time.
                    if (!line) begin
                        cnt <= '0;
                    end else if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    frame_idx <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
